pipeline_mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch and data-access stages of the pipelined CPU.
- Accepts one request at a time and drives the RAM handshake.
- Returns read data and one-cycle ihit/dhit pulses. The hazard unit consumes these pulses for its stall and enable decisions.
- Data accesses have priority. A streak limit bounds instruction-fetch starvation. A timeout watchdog traps a hung RAM.

---
 rtl/pipeline_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Data has priority; a streak limit forces fetches; a watchdog traps a hung RAM.
module pipeline_mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dhit,
  input  logic              halt,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              arb_busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE, IFETCH, DACCESS, ERR
  } state_t;

  localparam logic [3:0] SMAX  = 4'(STARVE_MAX);
  localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] streak;
  logic [7:0] wd;
  logic       dreq;
  logic       ireq;
  logic       starve;
  logic       dgrant;
  logic       igrant;

  always_comb begin
    dreq   = dREN | dWEN;
    ireq   = iREN & ~halt;
    starve = ireq & (streak == SMAX);
    dgrant = (state == IDLE) & dreq & ~starve;
    igrant = (state == IDLE) & ~dgrant & ireq;
  end

  // streak only tracks data grants that overtook a live fetch
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak <= '0;
    end else if (!iREN || igrant) begin
      streak <= '0;
    end else if (dgrant && streak != SMAX) begin
      streak <= streak + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      wd          <= '0;
      iload       <= '0;
      dload       <= '0;
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      ramREN      <= 1'b0;
      ramWEN      <= 1'b0;
      ramaddr     <= '0;
      ramstore    <= '0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dgrant) begin
            state    <= DACCESS;
            wd       <= '0;
            ramaddr  <= daddr;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
            arb_busy <= 1'b1;
            if (dWEN) ramstore <= dstore;
          end else if (igrant) begin
            state    <= IFETCH;
            wd       <= '0;
            ramaddr  <= iaddr;
            ramREN   <= 1'b1;
            arb_busy <= 1'b1;
          end
        end
        IFETCH, DACCESS: begin
          if (ram_ready) begin
            if (state == IFETCH) begin
              iload <= ramload;
              ihit  <= 1'b1;
            end else begin
              if (!ramWEN) dload <= ramload;
              dhit <= 1'b1;
            end
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            arb_busy <= 1'b0;
          end else if (wd == WLAST) begin
            state       <= ERR;
            ramREN      <= 1'b0;
            ramWEN      <= 1'b0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        ERR: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Scoreboard bench for pipeline_mem_arbiter.
// Requests come from queues; a simple RAM model answers the strobes.
module tb_pipeline_mem_arbiter;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] dload;
  logic        dhit;
  logic        halt = 1'b0;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;
  logic        arb_busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass = 0;
  int ram_delay = 1;
  int rcnt = 0;
  bit ram_hold = 0;
  bit ram_force = 0;

  ent_t        sb[$];
  ent_t        dq[$];
  logic [31:0] iq[$];
  ent_t        e;
  logic [31:0] exp_dload = '0;
  bit          prev_strobe = 0;
  bit          prev_hit = 0;
  bit          ok;

  pipeline_mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return {a[15:0], 16'h0} ^ 32'h1357_9BDF ^ a;
  endfunction

  // RAM model
  always @(negedge CLK) begin
    if (!nRST) begin
      ram_ready = 1'b0;
      rcnt = 0;
    end else if (ram_ready) begin
      ram_ready = 1'b0;
      rcnt = 0;
    end else if (ram_force) begin
      ram_ready = 1'b1;
      ramload = 32'hBAD0_BAD0;
    end else if ((ramREN || ramWEN) && !ram_hold) begin
      if (rcnt >= ram_delay) begin
        ram_ready = 1'b1;
        ramload = mem(ramaddr);
        rcnt = 0;
      end else begin
        rcnt++;
      end
    end else begin
      rcnt = 0;
    end
  end

  // Monitor, scoreboard and requester
  always @(negedge CLK) begin
    if (!nRST) begin
      prev_strobe = 0;
      prev_hit = 0;
      exp_dload = '0;
    end else begin
      if (prev_hit) begin
        n_checks++;
        if (ihit || dhit)
          $display("FAIL hit_pulse: ihit=%b dhit=%b want 0 0", ihit, dhit);
        else n_pass++;
      end
      if ((ramREN || ramWEN) && !prev_strobe) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL grant: unexpected grant addr=%h", ramaddr);
        end else if (ramaddr !== sb[0].addr ||
                     ramWEN !== (sb[0].kind == 2) ||
                     ramREN !== (sb[0].kind != 2) ||
                     (sb[0].kind == 2 && ramstore !== sb[0].data)) begin
          $display("FAIL grant: addr=%h wen=%b ren=%b st=%h want addr=%h kind=%0d st=%h",
                   ramaddr, ramWEN, ramREN, ramstore,
                   sb[0].addr, sb[0].kind, sb[0].data);
        end else n_pass++;
      end
      prev_strobe = ramREN || ramWEN;
      if (ihit || dhit) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL hit: unexpected ihit=%b dhit=%b", ihit, dhit);
        end else begin
          e = sb.pop_front();
          if (e.kind == 0) begin
            if (!ihit || dhit || iload !== e.data || arb_busy)
              $display("FAIL ihit: ihit=%b dhit=%b iload=%h busy=%b want iload=%h",
                       ihit, dhit, iload, arb_busy, e.data);
            else n_pass++;
          end else begin
            if (e.kind == 1) exp_dload = e.data;
            if (!dhit || ihit || dload !== exp_dload || arb_busy)
              $display("FAIL dhit: dhit=%b ihit=%b dload=%h busy=%b want dload=%h",
                       dhit, ihit, dload, arb_busy, exp_dload);
            else n_pass++;
          end
        end
      end
      prev_hit = ihit || dhit;
    end
    if (ihit && iq.size() > 0) iq.delete(0);
    if (dhit && dq.size() > 0) dq.delete(0);
    iREN = iq.size() > 0;
    iaddr = iREN ? iq[0] : '0;
    if (dq.size() > 0) begin
      dREN = 1'b1;
      dWEN = dq[0].kind == 2;
      daddr = dq[0].addr;
      dstore = dq[0].data;
    end else begin
      dREN = 1'b0;
      dWEN = 1'b0;
      daddr = '0;
      dstore = '0;
    end
  end

  task automatic wait_grant(output bit got);
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge CLK);
      got = ramREN || ramWEN;
    end
    n_checks++;
    if (!got) $display("FAIL wait_grant: no strobe within 30 cycles");
    else n_pass++;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((sb.size() || iq.size() || dq.size()) && c < 200) begin
      @(negedge CLK);
      c++;
    end
    n_checks++;
    if (sb.size() || iq.size() || dq.size())
      $display("FAIL %s_drain: left sb=%0d iq=%0d dq=%0d want 0",
               name, sb.size(), iq.size(), dq.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    sb.delete(); iq.delete(); dq.delete();
    halt = 0; ram_hold = 0; ram_force = 0; ram_delay = 1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({iload, dload, ihit, dhit, ramREN, ramWEN, ramaddr,
         ramstore, arb_busy, timeout_err} !== '0)
      $display("FAIL reset: outputs not zero iload=%h dload=%h addr=%h err=%b",
               iload, dload, ramaddr, timeout_err);
    else n_pass++;
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_fetch;
    int t;
    ram_delay = 1;
    sb.push_back(ent_t'{0, 32'h40, mem(32'h40)});
    iq.push_back(32'h40);
    wait_grant(ok);
    n_checks++;
    if (ramaddr !== 32'h40 || ramREN !== 1'b1 || arb_busy !== 1'b1)
      $display("FAIL fetch_grant: addr=%h ren=%b busy=%b want 40 1 1",
               ramaddr, ramREN, arb_busy);
    else n_pass++;
    t = 0;
    while (!ihit && t < 20) begin
      @(negedge CLK);
      t++;
    end
    n_checks++;
    if (t !== 2) $display("FAIL fetch_latency: got %0d want 2", t);
    else n_pass++;
    n_checks++;
    if (iload !== 32'h8C220004)
      $display("FAIL fetch_iload: got %h want 8c220004", iload);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (ihit !== 1'b0 || arb_busy !== 1'b0)
      $display("FAIL fetch_after: ihit=%b busy=%b want 0 0", ihit, arb_busy);
    else n_pass++;
    wait_drain("single_fetch");
  endtask

  task automatic test_priority;
    int c;
    sb.push_back(ent_t'{1, 32'h100, mem(32'h100)});
    sb.push_back(ent_t'{0, 32'h44, mem(32'h44)});
    dq.push_back(ent_t'{1, 32'h100, 32'h0});
    iq.push_back(32'h44);
    c = 0;
    while (!dhit && c < 30) begin
      @(negedge CLK);
      c++;
    end
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h44)
      $display("FAIL prio_next_fetch: ren=%b addr=%h want 1 44", ramREN, ramaddr);
    else n_pass++;
    wait_drain("priority");
  endtask

  task automatic test_write;
    sb.push_back(ent_t'{2, 32'h200, 32'hDEADBEEF});
    dq.push_back(ent_t'{2, 32'h200, 32'hDEADBEEF});
    wait_grant(ok);
    n_checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEADBEEF)
      $display("FAIL write_strobe: wen=%b ren=%b st=%h want 1 0 deadbeef",
               ramWEN, ramREN, ramstore);
    else n_pass++;
    wait_drain("write");
    n_checks++;
    if (dload !== mem(32'h100))
      $display("FAIL write_dload: got %h want %h", dload, mem(32'h100));
    else n_pass++;
  endtask

  task automatic test_starvation;
    ram_delay = 0;
    for (int i = 0; i < 4; i++)
      sb.push_back(ent_t'{1, 32'h600 + 32'(4 * i), mem(32'h600 + 32'(4 * i))});
    sb.push_back(ent_t'{0, 32'h80, mem(32'h80)});
    for (int i = 4; i < 6; i++)
      sb.push_back(ent_t'{1, 32'h600 + 32'(4 * i), mem(32'h600 + 32'(4 * i))});
    for (int i = 0; i < 6; i++)
      dq.push_back(ent_t'{1, 32'h600 + 32'(4 * i), 32'h0});
    iq.push_back(32'h80);
    wait_drain("starvation");
    ram_delay = 1;
  endtask

  task automatic test_halt;
    int c;
    int n;
    ram_delay = 2;
    sb.push_back(ent_t'{0, 32'h300, mem(32'h300)});
    iq.push_back(32'h300);
    iq.push_back(32'h304);
    wait_grant(ok);
    halt = 1'b1;
    c = 0;
    while (iq.size() > 1 && c < 30) begin
      @(negedge CLK);
      c++;
    end
    n = 0;
    repeat (8) begin
      @(negedge CLK);
      if (ramREN) n++;
    end
    n_checks++;
    if (n !== 0 || iREN !== 1'b1)
      $display("FAIL halt_block: strobe cycles=%0d iREN=%b want 0 1", n, iREN);
    else n_pass++;
    sb.push_back(ent_t'{1, 32'h500, mem(32'h500)});
    sb.push_back(ent_t'{0, 32'h304, mem(32'h304)});
    dq.push_back(ent_t'{1, 32'h500, 32'h0});
    c = 0;
    while (sb.size() > 1 && c < 30) begin
      @(negedge CLK);
      c++;
    end
    n_checks++;
    if (sb.size() !== 1) $display("FAIL halt_data: sb=%0d want 1", sb.size());
    else n_pass++;
    halt = 1'b0;
    wait_drain("halt");
    ram_delay = 1;
  endtask

  task automatic test_timeout;
    int n;
    ram_hold = 1;
    sb.push_back(ent_t'{0, 32'h700, mem(32'h700)});
    iq.push_back(32'h700);
    wait_grant(ok);
    repeat (14) @(negedge CLK);
    n_checks++;
    if (timeout_err !== 1'b0 || ramREN !== 1'b1)
      $display("FAIL timeout_early: err=%b ren=%b want 0 1", timeout_err, ramREN);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (timeout_err !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0 || arb_busy !== 1'b0)
      $display("FAIL timeout_trap: err=%b ren=%b wen=%b busy=%b want 1 0 0 0",
               timeout_err, ramREN, ramWEN, arb_busy);
    else n_pass++;
    sb.delete();
    iq.delete();
    ram_hold = 0;
    #1 ram_force = 1;
    @(negedge CLK);
    #1 ram_force = 0;
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (ihit || dhit || ramREN || ramWEN || !timeout_err) n++;
    end
    n_checks++;
    if (n !== 0) $display("FAIL timeout_sticky: bad cycles=%0d want 0", n);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    ram_hold = 1;
    sb.push_back(ent_t'{0, 32'h88, mem(32'h88)});
    iq.push_back(32'h88);
    wait_grant(ok);
    n_checks++;
    if (ramaddr !== 32'h88 || arb_busy !== 1'b1)
      $display("FAIL async_pre: addr=%h busy=%b want 88 1", ramaddr, arb_busy);
    else n_pass++;
    #3 nRST = 1'b0;
    #1;
    n_checks++;
    if ({iload, dload, ihit, dhit, ramREN, ramWEN, ramaddr,
         ramstore, arb_busy, timeout_err} !== '0)
      $display("FAIL async_reset: ren=%b addr=%h busy=%b st=%h want all 0",
               ramREN, ramaddr, arb_busy, ramstore);
    else n_pass++;
    sb.delete();
    iq.delete();
    ram_hold = 0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_write();
    test_starvation();
    test_halt();
    test_timeout();
    test_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
